// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit and its predictor partner.
// Holds the default widths; queue entry field offsets are derived in the
// top level from the actual PC_W parameter.
package branch_resolve_unit_pkg;

    localparam int unsigned BP_PC_W       = 6;   // instruction word-address width
    localparam int unsigned BP_TABLE_SIZE = 64;  // gshare pattern table entries
    localparam int unsigned BP_DEPTH      = 4;   // in-flight branch queue depth
    localparam int unsigned BP_CNT_W      = 16;  // statistics counter width

    // Queue entry width for a given PC width: {pc, pred, target}.
    function automatic int unsigned bp_entry_w(input int unsigned pc_w);
        return 2 * pc_w + 1;
    endfunction

endpackage

// File: rtl/branch_info_fifo.sv
// In-order FIFO of in-flight branch records.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_wdata at tail (ignored when full unless popping)
//   i_pop          drop head entry (ignored when empty)
//   i_clear        empty the queue; dominates push and pop
//   o_rdata        head entry (valid when !o_empty)
//   o_full/o_empty occupancy flags, o_count occupancy (0..DEPTH)
module branch_info_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // A pop frees the slot in the same edge, so push-while-full is accepted
    // when accompanied by a pop.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues predicted branches from fetch, compares them
// against the EX outcome, raises a one-cycle flush/redirect on mispredict,
// trains the predictor and keeps saturating statistics.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   push/push_pc/push_pred/push_target   branch issued by fetch
//   full                            queue full (fetch must stall branches)
//   resolve_valid/_taken/_target    EX outcome for the oldest branch
//   flush, redirect_pc              mispredict pulse and correct next PC
//   upd_branch, upd_pc, upd_taken   predictor training port
//   branch_count, mispred_count     saturating statistics
//   err_underflow, err_overflow     sticky protocol error flags
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned PC_W  = BP_PC_W,
    parameter int unsigned DEPTH = BP_DEPTH,
    parameter int unsigned CNT_W = BP_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              push_pred,
    input  logic [PC_W-1:0]   push_target,
    output logic              full,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic [PC_W-1:0]   resolve_target,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              upd_branch,
    output logic [PC_W-1:0]   upd_pc,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispred_count,
    output logic              err_underflow,
    output logic              err_overflow
);

    localparam int unsigned ENT_W       = bp_entry_w(PC_W);
    localparam int unsigned ENT_TGT_LSB = 0;
    localparam int unsigned ENT_PRED    = PC_W;
    localparam int unsigned ENT_PC_LSB  = PC_W + 1;
    localparam int unsigned CW          = $clog2(DEPTH) + 1;

    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_pred;
    logic [PC_W-1:0]  w_head_tgt;
    logic             w_resolve;
    logic             w_mispred;
    logic [PC_W-1:0]  w_correct_pc;
    logic             w_clear;

    logic             r_flush;
    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_upd_branch;
    logic [PC_W-1:0]  r_upd_pc;
    logic             r_upd_taken;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispred_count;
    logic             r_err_underflow;
    logic             r_err_overflow;

    assign w_wdata     = {push_pc, push_pred, push_target};
    assign w_head_pc   = w_head[ENT_PC_LSB +: PC_W];
    assign w_head_pred = w_head[ENT_PRED];
    assign w_head_tgt  = w_head[ENT_TGT_LSB +: PC_W];

    assign w_resolve    = resolve_valid & ~w_empty;
    assign w_mispred    = (w_head_pred != resolve_taken) |
                          (w_head_pred & resolve_taken & (w_head_tgt != resolve_target));
    assign w_correct_pc = resolve_taken ? resolve_target : (w_head_pc + PC_W'(1));
    // Everything behind a mispredicted head is wrong-path: drop it all,
    // including a push arriving in the same cycle.
    assign w_clear      = w_resolve & w_mispred;

    branch_info_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (push),
        .i_pop   (w_resolve),
        .i_clear (w_clear),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    a_full_matches_count: assert property (@(posedge clk) disable iff (!reset)
        w_full == (w_count == CW'(DEPTH)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_upd_branch    <= 1'b0;
            r_upd_pc        <= '0;
            r_upd_taken     <= 1'b0;
            r_branch_count  <= '0;
            r_mispred_count <= '0;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_upd_branch  <= w_resolve;
            r_upd_pc      <= w_resolve ? w_head_pc : '0;
            r_upd_taken   <= w_resolve & resolve_taken;
            r_flush       <= w_clear;
            r_redirect_pc <= w_clear ? w_correct_pc : '0;

            if (w_resolve && (r_branch_count != '1))
                r_branch_count <= r_branch_count + CNT_W'(1);
            if (w_clear && (r_mispred_count != '1))
                r_mispred_count <= r_mispred_count + CNT_W'(1);

            if (resolve_valid && w_empty)
                r_err_underflow <= 1'b1;
            if (push && w_full && !resolve_valid)
                r_err_overflow <= 1'b1;
        end
    end

    assign full          = w_full;
    assign flush         = r_flush;
    assign redirect_pc   = r_redirect_pc;
    assign upd_branch    = r_upd_branch;
    assign upd_pc        = r_upd_pc;
    assign upd_taken     = r_upd_taken;
    assign branch_count  = r_branch_count;
    assign mispred_count = r_mispred_count;
    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int unsigned PC_W  = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic              clk;
    logic              reset;
    logic              push;
    logic [PC_W-1:0]   push_pc;
    logic              push_pred;
    logic [PC_W-1:0]   push_target;
    logic              full;
    logic              resolve_valid;
    logic              resolve_taken;
    logic [PC_W-1:0]   resolve_target;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic              upd_branch;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispred_count;
    logic              err_underflow;
    logic              err_overflow;

    branch_resolve_unit #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .push_pc        (push_pc),
        .push_pred      (push_pred),
        .push_target    (push_target),
        .full           (full),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .upd_branch     (upd_branch),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count),
        .err_underflow  (err_underflow),
        .err_overflow   (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic [PC_W-1:0] tgt;
    } ent_t;

    typedef struct {
        logic            ub;
        logic [PC_W-1:0] upc;
        logic            ut;
        logic            fl;
        logic [PC_W-1:0] red;
    } res_t;

    typedef struct {
        logic            p;
        logic [PC_W-1:0] ppc;
        logic            ppred;
        logic [PC_W-1:0] ptgt;
        logic            rv;
        logic            rt;
        logic [PC_W-1:0] rtgt;
        logic            e_ub;
        logic [PC_W-1:0] e_upc;
        logic            e_fl;
        logic [PC_W-1:0] e_red;
    } vec_t;

    ent_t            mq[$];
    res_t            sb[$];
    logic [CNT_W-1:0] m_bc;
    logic [CNT_W-1:0] m_mc;
    logic            m_eu;
    logic            m_eo;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_bc = '0;
        m_mc = '0;
        m_eu = 1'b0;
        m_eo = 1'b0;
    endtask

    // One clock: drive inputs, predict results into the scoreboard, then
    // compare the registered outputs one edge later.
    task automatic cycle(input logic p, input logic [PC_W-1:0] ppc, input logic ppred,
                         input logic [PC_W-1:0] ptgt, input logic rv, input logic rt,
                         input logic [PC_W-1:0] rtgt);
        res_t e;
        ent_t h;
        ent_t n;
        logic clr;
        logic mis;
        e = '{ub: 1'b0, upc: '0, ut: 1'b0, fl: 1'b0, red: '0};
        clr = 1'b0;
        push = p; push_pc = ppc; push_pred = ppred; push_target = ptgt;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;
        if (rv) begin
            if (mq.size() == 0) begin
                m_eu = 1'b1;
            end else begin
                h = mq.pop_front();
                mis = (h.pred != rt) || (h.pred && rt && (h.tgt != rtgt));
                e.ub = 1'b1; e.upc = h.pc; e.ut = rt;
                if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
                if (mis) begin
                    e.fl = 1'b1;
                    e.red = rt ? rtgt : PC_W'(h.pc + 6'd1);
                    if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
                    mq.delete();
                    clr = 1'b1;
                end
            end
        end
        if (p && !clr) begin
            if (mq.size() < DEPTH) begin
                n.pc = ppc; n.pred = ppred; n.tgt = ptgt;
                mq.push_back(n);
            end else begin
                m_eo = 1'b1;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("upd_branch", upd_branch, e.ub);
            chk("upd_pc", upd_pc, e.upc);
            chk("upd_taken", upd_taken, e.ut);
            chk("flush", flush, e.fl);
            chk("redirect_pc", redirect_pc, e.red);
            chk("branch_count", branch_count, m_bc);
            chk("mispred_count", mispred_count, m_mc);
            chk("err_underflow", err_underflow, m_eu);
            chk("err_overflow", err_overflow, m_eo);
            chk("full", full, (mq.size() == DEPTH) ? 1 : 0);
        end
        push = 1'b0; resolve_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_redirect"}, redirect_pc, 0);
        chk({tag, "_upd_branch"}, upd_branch, 0);
        chk({tag, "_upd_pc"}, upd_pc, 0);
        chk({tag, "_upd_taken"}, upd_taken, 0);
        chk({tag, "_branch_count"}, branch_count, 0);
        chk({tag, "_mispred_count"}, mispred_count, 0);
        chk({tag, "_err_underflow"}, err_underflow, 0);
        chk({tag, "_err_overflow"}, err_overflow, 0);
        chk({tag, "_full"}, full, 0);
    endtask

    vec_t tbl[13];
    logic [PC_W-1:0] drain_pc[4];

    initial begin
        tbl[0]  = '{1'b1,  6'd5, 1'b1, 6'd20, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[1]  = '{1'b0,  6'd0, 1'b0, 6'd0,  1'b1, 1'b1, 6'd20, 1'b1, 6'd5,  1'b0, 6'd0};
        tbl[2]  = '{1'b1, 6'd63, 1'b1, 6'd7,  1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[3]  = '{1'b0,  6'd0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1, 6'd63, 1'b1, 6'd0};
        tbl[4]  = '{1'b1,  6'd3, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[5]  = '{1'b1,  6'd4, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[6]  = '{1'b1,  6'd5, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[7]  = '{1'b0,  6'd0, 1'b0, 6'd0,  1'b1, 1'b1, 6'd40, 1'b1, 6'd3,  1'b1, 6'd40};
        tbl[8]  = '{1'b0,  6'd0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[9]  = '{1'b1,  6'd9, 1'b1, 6'd10, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[10] = '{1'b0,  6'd0, 1'b0, 6'd0,  1'b1, 1'b1, 6'd12, 1'b1, 6'd9,  1'b1, 6'd12};
        tbl[11] = '{1'b1,  6'd2, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0};
        tbl[12] = '{1'b0,  6'd0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1, 6'd2,  1'b0, 6'd0};

        reset = 1'b0;
        push = 1'b0; push_pc = '0; push_pred = 1'b0; push_target = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_all_zero("reset");

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].p, tbl[i].ppc, tbl[i].ppred, tbl[i].ptgt,
                  tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
            chk($sformatf("tbl%0d_upd_branch", i), upd_branch, tbl[i].e_ub);
            chk($sformatf("tbl%0d_upd_pc", i), upd_pc, tbl[i].e_upc);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].e_fl);
            chk($sformatf("tbl%0d_redirect", i), redirect_pc, tbl[i].e_red);
        end
        chk("tbl_err_underflow", err_underflow, 1);
        chk("tbl_branch_count", branch_count, 5);
        chk("tbl_mispred_count", mispred_count, 3);

        // Fill, overflow, push+resolve while full, then drain in order.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, PC_W'(10 + i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        chk("fill_full", full, 1);
        chk("fill_no_overflow", err_overflow, 0);
        cycle(1'b1, 6'd14, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        chk("overflow_set", err_overflow, 1);
        cycle(1'b1, 6'd15, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0);
        chk("pushpop_full", full, 1);
        chk("pushpop_pc", upd_pc, 10);
        drain_pc[0] = 6'd11; drain_pc[1] = 6'd12; drain_pc[2] = 6'd13; drain_pc[3] = 6'd15;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0);
            chk($sformatf("drain%0d_pc", i), upd_pc, drain_pc[i]);
            chk($sformatf("drain%0d_flush", i), flush, 0);
        end
        chk("drain_empty_full", full, 0);

        // Reset in the middle of traffic with a resolve pending.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, PC_W'(20 + i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd33);
        chk("pre_reset_flush", flush, 1);
        cycle(1'b1, 6'd30, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 6'd31, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        cycle(1'b1, 6'd32, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0);
        chk("pre_reset_upd", upd_branch, 1);
        resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 6'd50;
        push = 1'b1; push_pc = 6'd40;
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        push = 1'b0; resolve_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        chk("post_reset_full", full, 0);
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        chk("post_reset_no_flush", flush, 0);
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd0);
        chk("post_reset_underflow", err_underflow, 1);
        chk("post_reset_no_upd", upd_branch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
